// File: rtl/pcm_fir_pkg.sv
// Shared types, coefficient tables and output rounding/saturation for the
// single-MAC FIR compensation decimator.
package pcm_fir_pkg;

    localparam int PCM_W     = 16;
    localparam int COEF_W    = 16;
    localparam int COMP_TAPS = 60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_ROUND
    } fir_state_t;

    // Symmetric 32-tap inverse-sinc kernel in taps 0..31 (sum = 32768); taps 32..59 are zero.
    localparam logic signed [COEF_W-1:0] COMP_COEFS [0:COMP_TAPS-1] = '{
        -16'sd20,   16'sd30,    -16'sd45,   16'sd65,    -16'sd90,   16'sd120,
        -16'sd160,  16'sd210,   -16'sd280,  16'sd370,   -16'sd500,  16'sd690,
        -16'sd1000, 16'sd1600,  16'sd3400,  16'sd11994, 16'sd11994, 16'sd3400,
        16'sd1600,  -16'sd1000, 16'sd690,   -16'sd500,  16'sd370,   -16'sd280,
        16'sd210,   -16'sd160,  16'sd120,   -16'sd90,   16'sd65,    -16'sd45,
        16'sd30,    -16'sd20,   16'sd0,     16'sd0,     16'sd0,     16'sd0,
        16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,
        16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,
        16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,
        16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0
    };

    localparam logic signed [COEF_W-1:0] TEST_COEF = 16'sd4096;
    localparam logic signed [63:0]       RND_CONST = 64'sd16384;

    // Q1.15 rescale with round-half-up
    function automatic logic signed [63:0] round_q15(input logic signed [63:0] acc);
        return (acc + RND_CONST) >>> 15;
    endfunction

    function automatic logic signed [PCM_W-1:0] sat_pcm(input logic signed [63:0] val);
        if (val > 64'sd32767)
            return 16'sh7fff;
        else if (val < -64'sd32768)
            return 16'sh8000;
        else
            return val[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational tap-coefficient lookup; keeps table selection out of the datapath.
module fir_coef_rom
    import pcm_fir_pkg::*;
#(
    parameter int COEF_SEL = 0,
    parameter int K_W      = 5
) (
    input  logic [K_W-1:0]            k,
    output logic signed [COEF_W-1:0]  coef
);

    always_comb begin
        coef = '0;
        if (COEF_SEL == 1)
            coef = TEST_COEF;
        else if (int'(k) < COMP_TAPS)
            coef = COMP_COEFS[6'(k)];
    end

endmodule

// File: rtl/pcm_fir_decim2.sv
// Decimate-by-2 FIR droop compensator: one MAC pass of NTAPS cycles per output,
// triggered by every second accepted PCM sample.
module pcm_fir_decim2
    import pcm_fir_pkg::*;
#(
    parameter int NTAPS    = 32,
    parameter int COEF_SEL = 0,
    parameter int ACC_W    = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [PCM_W-1:0] in_data,
    output logic                    out_valid,
    output logic signed [PCM_W-1:0] out_data,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PTR_W = $clog2(NTAPS);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NTAPS - 1);

    fir_state_t                 state;
    logic                       phase;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           tap_k;
    logic signed [PCM_W-1:0]    sample_buf [NTAPS];
    logic signed [ACC_W-1:0]    acc;
    logic signed [COEF_W-1:0]   coef;
    logic signed [2*PCM_W-1:0]  prod;

    fir_coef_rom #(
        .COEF_SEL (COEF_SEL),
        .K_W      (PTR_W)
    ) u_coef_rom (
        .k    (tap_k),
        .coef (coef)
    );

    assign prod = (2*PCM_W)'(sample_buf[rd_ptr]) * (2*PCM_W)'(coef);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tap_k     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NTAPS; i++)
                sample_buf[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sample_buf[wr_ptr] <= in_data;
                        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
                        phase  <= ~phase;
                        if (phase) begin
                            // newest sample sits at the slot just written
                            rd_ptr <= wr_ptr;
                            tap_k  <= '0;
                            acc    <= '0;
                            busy   <= 1'b1;
                            state  <= ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    acc    <= acc + ACC_W'(prod);
                    rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - PTR_W'(1);
                    tap_k  <= tap_k + PTR_W'(1);
                    if (tap_k == LAST)
                        state <= ST_ROUND;
                    if (in_valid)
                        overrun <= 1'b1;
                end
                ST_ROUND: begin
                    out_data  <= sat_pcm(round_q15(64'(acc)));
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                    if (in_valid)
                        overrun <= 1'b1;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_fir_decim2.sv
// Bench for pcm_fir_decim2: two instances (test table and compensation table)
// share the stimulus; a history-based reference model predicts every output.
module tb_pcm_fir_decim2;
    import pcm_fir_pkg::*;

    localparam int NT = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic out_valid_t, busy_t, overrun_t;
    logic out_valid_c, busy_c, overrun_c;
    logic signed [15:0] out_data_t, out_data_c;

    always #5 clk = ~clk;

    pcm_fir_decim2 #(.NTAPS(NT), .COEF_SEL(1), .ACC_W(40)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_t), .out_data(out_data_t), .busy(busy_t), .overrun(overrun_t)
    );

    pcm_fir_decim2 #(.NTAPS(NT), .COEF_SEL(0), .ACC_W(40)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_c), .out_data(out_data_c), .busy(busy_c), .overrun(overrun_c)
    );

    typedef struct {
        int due;
        int yt;
        int yc;
    } exp_t;

    typedef struct {
        bit rst_first;
        int din;
        bit chk;
        int dout;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   hist[$];
    int   trig = -1000;
    bit   m_ovr = 1'b0;
    int   last_t = 0;
    int   last_c = 0;
    int   pulses = 0;
    int   first_vld_cyc = -1;

    task automatic chk(input string name, input logic signed [31:0] act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    // y[n] = sat(round(sum_k h[k] * x[n-k] / 2^15)), x before reset = 0
    function automatic int model_y(input bit comp);
        longint s = 0;
        int n = hist.size() - 1;
        for (int k = 0; k < NT; k++)
            if (n - k >= 0)
                s += longint'(comp ? int'(COMP_COEFS[k]) : 4096) * hist[n - k];
        s = (s + 16384) >>> 15;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic step(input bit r, input bit v, input int d);
        bit exp_v;
        bit exp_busy;
        rst = r;
        in_valid = v;
        in_data = 16'(d);
        if (r) begin
            hist.delete();
            exp_q.delete();
            trig = -1000;
            m_ovr = 1'b0;
            last_t = 0;
            last_c = 0;
        end else if (v) begin
            if (cyc >= trig + 1 && cyc <= trig + NT + 1) begin
                m_ovr = 1'b1;
            end else begin
                hist.push_back(int'(in_data));
                if (hist.size() % 2 == 0) begin
                    trig = cyc;
                    exp_q.push_back('{cyc + NT + 2, model_y(1'b0), model_y(1'b1)});
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_v = (exp_q.size() > 0 && exp_q[0].due == cyc);
        exp_busy = (cyc >= trig + 1 && cyc <= trig + NT + 1);
        if (exp_v) begin
            last_t = exp_q[0].yt;
            last_c = exp_q[0].yc;
            void'(exp_q.pop_front());
        end
        if (out_valid_t === 1'b1) begin
            pulses++;
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
        end
        chk("valid_t", out_valid_t, int'(exp_v));
        chk("valid_c", out_valid_c, int'(exp_v));
        chk("data_t", out_data_t, last_t);
        chk("data_c", out_data_c, last_c);
        chk("busy_t", busy_t, int'(exp_busy));
        chk("busy_c", busy_c, int'(exp_busy));
        chk("overrun_t", overrun_t, int'(m_ovr));
        chk("overrun_c", overrun_c, int'(m_ovr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0);
        idle(3);
    endtask

    initial begin
        vec_t tbl[$];
        int t0;
        int trg;
        int g;
        int d;

        // impulse, DC, positive and negative saturation with the all-4096 table
        for (int i = 0; i < 36; i++)
            tbl.push_back('{i == 0, (i == 0) ? 32767 : 0, i % 2 == 1, (i <= 31) ? 4096 : 0});
        for (int i = 0; i < 64; i++)
            tbl.push_back('{i == 0, 1, (i % 2 == 1) && (i >= 31), 4});
        for (int i = 0; i < 40; i++)
            tbl.push_back('{i == 0, 16384, (i % 2 == 1) && (i >= 31), 32767});
        for (int i = 0; i < 40; i++)
            tbl.push_back('{i == 0, -32768, (i % 2 == 1) && (i >= 31), -32768});

        step(1'b1, 1'b0, 0);
        chk("rst_valid", out_valid_t, 0);
        chk("rst_data", out_data_t, 0);
        chk("rst_busy", busy_t, 0);
        chk("rst_overrun", overrun_t, 0);
        idle(3);

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            step(1'b0, 1'b1, tbl[i].din);
            idle(63);
            if (tbl[i].chk) chk("tbl_out", out_data_t, tbl[i].dout);
        end

        // latency and overrun: samples at relative cycles 0, 64, 70
        do_reset();
        t0 = cyc;
        pulses = 0;
        first_vld_cyc = -1;
        step(1'b0, 1'b1, 1000);
        idle(63);
        step(1'b0, 1'b1, 2000);
        idle(5);
        chk("ovr_before", overrun_t, 0);
        step(1'b0, 1'b1, 30000);
        chk("ovr_after", overrun_t, 1);
        idle(t0 + 128 - cyc);
        chk("lat_first_cycle", first_vld_cyc - t0, 98);
        chk("lat_pulses", pulses, 1);
        chk("lat_first_data", out_data_t, 375);
        step(1'b0, 1'b1, 3000);
        idle(63);
        step(1'b0, 1'b1, 4000);
        idle(63);
        chk("drop_data", out_data_t, 1250);
        chk("drop_pulses", pulses, 2);
        chk("ovr_sticky", overrun_t, 1);

        // reset ten cycles into a MAC pass
        do_reset();
        step(1'b0, 1'b1, 111);
        idle(63);
        trg = cyc;
        step(1'b0, 1'b1, 222);
        idle(trg + 10 - cyc);
        step(1'b1, 1'b0, 0);
        pulses = 0;
        idle(60);
        chk("rstmac_pulses", pulses, 0);
        chk("rstmac_data", out_data_t, 0);
        chk("rstmac_busy", busy_t, 0);
        chk("rstmac_overrun", overrun_t, 0);
        step(1'b0, 1'b1, 500);
        idle(63);
        step(1'b0, 1'b1, 700);
        idle(63);
        chk("rstmac_next", out_data_t, 150);
        chk("rstmac_next_pulses", pulses, 1);

        // compensation table steady-state DC gain
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 10000);
            idle(63);
        end
        chk("comp_dc_tol", int'(out_data_c >= 16'sd9999 && out_data_c <= 16'sd10001), 1);

        // random data with gaps around the overrun boundary
        do_reset();
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: g = NT + 1;
                1: g = NT + 2;
                default: g = int'($urandom_range(1, 90));
            endcase
            d = int'($urandom_range(0, 65535)) - 32768;
            step(1'b0, 1'b1, d);
            idle(g - 1);
        end
        idle(NT + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
